// File: rtl/range_monitor_pkg.sv
// Shared types and elaboration helpers for the fixed-point range monitor.
//   mon_mode_t  : reporting mode (silent / $error per event / $fatal on first)
//   RUN_W       : width of the per-channel out-of-range run counter (PERSIST <= 255)
//   fix_lim()   : converts a real limit to an integer code (ceil or floor), clamped
//   code2real() : converts a signed code back to a real for messages
package range_monitor_pkg;

  typedef enum logic [1:0] {
    MON_SILENT = 2'd0,
    MON_ERROR  = 2'd1,
    MON_FATAL  = 2'd2
  } mon_mode_t;

  localparam int RUN_W = 8;

  // Scale r by 2**-exp, round up (up=1) or down (up=0), then clamp to the
  // signed w-bit range. Clamping happens on the real value first so the
  // real-to-integer conversion can never overflow.
  function automatic longint fix_lim(real r, int exp, int w, bit up);
    real    s;
    longint t;
    longint vmax;
    longint vmin;
    s = r;
    if (exp < 0) begin
      for (int i = 0; i < -exp; i++) s = s * 2.0;
    end else begin
      for (int i = 0; i < exp; i++) s = s / 2.0;
    end
    vmax = (longint'(1) <<< (w - 1)) - 1;
    vmin = -(longint'(1) <<< (w - 1));
    if (s >= real'(vmax)) return vmax;
    if (s <= real'(vmin)) return vmin;
    t = $rtoi(s);  // truncates toward zero
    if (up) begin
      if (real'(t) < s) t = t + 1;
    end else begin
      if (real'(t) > s) t = t - 1;
    end
    return t;
  endfunction

  function automatic real code2real(logic signed [63:0] c, int exp);
    real s;
    s = real'(c);
    if (exp < 0) begin
      for (int i = 0; i < -exp; i++) s = s / 2.0;
    end else begin
      for (int i = 0; i < exp; i++) s = s * 2.0;
    end
    return s;
  endfunction

endpackage

// File: rtl/range_monitor_real_ch.sv
// One monitored channel: limit compare, persistence run counter with
// re-arm, single-cycle event generation, sticky flag and saturating count.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cke, clr          sample enable, synchronous clear (clr wins)
//   code              signed sample code
//   hit               combinational: this edge completes an event
//   viol_now          registered one-cycle event pulse
//   viol_sticky       sticky event flag
//   viol_cnt          saturating event count
module range_check_ch
  import range_monitor_pkg::*;
#(
  parameter int     WIDTH   = 16,
  parameter int     PERSIST = 1,
  parameter int     CNT_W   = 16,
  parameter longint LO_FIX  = 0,
  parameter longint HI_FIX  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cke,
  input  logic             clr,
  input  logic [WIDTH-1:0] code,
  output logic             hit,
  output logic             viol_now,
  output logic             viol_sticky,
  output logic [CNT_W-1:0] viol_cnt
);

  localparam logic signed [WIDTH-1:0] LO_C       = WIDTH'(LO_FIX);
  localparam logic signed [WIDTH-1:0] HI_C       = WIDTH'(HI_FIX);
  localparam logic [RUN_W-1:0]        PERSIST_C  = RUN_W'(PERSIST);
  localparam logic [RUN_W-1:0]        PERSIST_M1 = RUN_W'(PERSIST - 1);

  logic signed [WIDTH-1:0] code_s;
  logic                    out_rng;
  logic [RUN_W-1:0]        run_reg;
  logic [RUN_W-1:0]        run_next;
  logic                    now_reg;
  logic                    sticky_reg;
  logic [CNT_W-1:0]        cnt_reg;

  assign code_s = code;

  // The run saturates at PERSIST, so an unbroken violation fires only on the
  // sample that moves it from PERSIST-1 to PERSIST; an in-range sample re-arms.
  always_comb begin
    out_rng  = (code_s < LO_C) || (code_s > HI_C);
    hit      = cke && !clr && out_rng && (run_reg == PERSIST_M1);
    run_next = run_reg;
    if (cke) begin
      if (!out_rng) begin
        run_next = '0;
      end else if (run_reg != PERSIST_C) begin
        run_next = run_reg + RUN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_reg    <= '0;
      now_reg    <= 1'b0;
      sticky_reg <= 1'b0;
      cnt_reg    <= '0;
    end else if (clr) begin
      run_reg    <= '0;
      now_reg    <= 1'b0;
      sticky_reg <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      run_reg <= run_next;
      now_reg <= hit;
      if (hit) begin
        sticky_reg <= 1'b1;
        if (cnt_reg != {CNT_W{1'b1}}) cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign viol_now    = now_reg;
  assign viol_sticky = sticky_reg;
  assign viol_cnt    = cnt_reg;

endmodule

// File: rtl/range_monitor_real.sv
// Multi-channel range monitor for fixed-point reals (value = code * 2**EXPONENT).
// Each channel flags a violation after PERSIST consecutive out-of-range
// samples; the first flagged violation (channel, code, timestamp) is captured.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   cke           sample enable
//   clr           synchronous clear of all sticky/count/capture/timestamp state
//   in            packed signed codes, channel k = in[k*WIDTH +: WIDTH]
//   viol_now      per-channel event pulse (registered)
//   viol_sticky   per-channel sticky flag
//   viol_any      OR of viol_sticky
//   viol_cnt      per-channel saturating event counts, CNT_W bits each
//   first_valid   first-event capture valid
//   first_ch      channel of first event
//   first_val     code that completed the first event
//   first_time    sample timestamp of the first event
module range_monitor_real
  import range_monitor_pkg::*;
#(
  parameter int        N_CH     = 4,
  parameter int        WIDTH    = 16,
  parameter int        EXPONENT = -12,
  parameter real       LO       = -1.0,
  parameter real       HI       = 1.0,
  parameter int        PERSIST  = 1,
  parameter int        CNT_W    = 16,
  parameter int        TIME_W   = 32,
  parameter mon_mode_t MODE     = MON_SILENT,
  localparam int       CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cke,
  input  logic                    clr,
  input  logic [N_CH*WIDTH-1:0]   in,
  output logic [N_CH-1:0]         viol_now,
  output logic [N_CH-1:0]         viol_sticky,
  output logic                    viol_any,
  output logic [N_CH*CNT_W-1:0]   viol_cnt,
  output logic                    first_valid,
  output logic [CH_W-1:0]         first_ch,
  output logic [WIDTH-1:0]        first_val,
  output logic [TIME_W-1:0]       first_time
);

  localparam longint LO_FIX = fix_lim(LO, EXPONENT, WIDTH, 1'b1);
  localparam longint HI_FIX = fix_lim(HI, EXPONENT, WIDTH, 1'b0);

  if (LO_FIX > HI_FIX) begin : g_lim_err
    $error("range_monitor_real: empty range, lo_fix=%0d > hi_fix=%0d", LO_FIX, HI_FIX);
  end

  logic [N_CH-1:0]   hit;
  logic [TIME_W-1:0] tcount_reg;
  logic              first_valid_reg;
  logic [CH_W-1:0]   first_ch_reg;
  logic [WIDTH-1:0]  first_val_reg;
  logic [TIME_W-1:0] first_time_reg;
  logic [CH_W-1:0]   pick_ch;
  logic [WIDTH-1:0]  pick_val;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    range_check_ch #(
      .WIDTH   (WIDTH),
      .PERSIST (PERSIST),
      .CNT_W   (CNT_W),
      .LO_FIX  (LO_FIX),
      .HI_FIX  (HI_FIX)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .cke         (cke),
      .clr         (clr),
      .code        (in[gi*WIDTH +: WIDTH]),
      .hit         (hit[gi]),
      .viol_now    (viol_now[gi]),
      .viol_sticky (viol_sticky[gi]),
      .viol_cnt    (viol_cnt[gi*CNT_W +: CNT_W])
    );
  end

  // Lowest index wins: scan downward so the last assignment is the lowest hit.
  always_comb begin
    pick_ch  = '0;
    pick_val = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (hit[k]) begin
        pick_ch  = CH_W'(k);
        pick_val = in[k*WIDTH +: WIDTH];
      end
    end
  end

  // Timestamp counts accepted samples; first_time takes the value seen by
  // the completing sample, i.e. before this edge's increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcount_reg      <= '0;
      first_valid_reg <= 1'b0;
      first_ch_reg    <= '0;
      first_val_reg   <= '0;
      first_time_reg  <= '0;
    end else if (clr) begin
      tcount_reg      <= '0;
      first_valid_reg <= 1'b0;
      first_ch_reg    <= '0;
      first_val_reg   <= '0;
      first_time_reg  <= '0;
    end else begin
      if (cke && (tcount_reg != {TIME_W{1'b1}})) tcount_reg <= tcount_reg + TIME_W'(1);
      if (!first_valid_reg && (|hit)) begin
        first_valid_reg <= 1'b1;
        first_ch_reg    <= pick_ch;
        first_val_reg   <= pick_val;
        first_time_reg  <= tcount_reg;
      end
    end
  end

  assign viol_any    = |viol_sticky;
  assign first_valid = first_valid_reg;
  assign first_ch    = first_ch_reg;
  assign first_val   = first_val_reg;
  assign first_time  = first_time_reg;

  // Diagnostic messages; only elaborated when a reporting mode is selected.
  if (MODE != MON_SILENT) begin : g_msg
    always_ff @(posedge clk) begin
      if (rst_n && (MODE == MON_ERROR)) begin
        for (int k = 0; k < N_CH; k++) begin
          if (hit[k]) begin
            $error("range_monitor_real: ch %0d value %f outside [%f, %f]", k,
                   code2real(64'($signed(in[k*WIDTH +: WIDTH])), EXPONENT),
                   code2real(64'(LO_FIX), EXPONENT), code2real(64'(HI_FIX), EXPONENT));
          end
        end
      end
      if (rst_n && (MODE == MON_FATAL) && first_valid_reg) begin
        $fatal(1, "range_monitor_real: ch %0d value %f outside [%f, %f] at sample %0d",
               first_ch_reg, code2real(64'($signed(first_val_reg)), EXPONENT),
               code2real(64'(LO_FIX), EXPONENT), code2real(64'(HI_FIX), EXPONENT),
               first_time_reg);
      end
    end
  end

endmodule

// File: tb/tb_range_monitor_real.sv
module tb_range_monitor_real;

  // WIDTH=16, EXPONENT=-12, LO=-1.0, HI=+1.0 -> lo_fix=-4096, hi_fix=4096
  localparam int LO_FIX = -4096;
  localparam int HI_FIX = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  // DUT A: PERSIST=3, CNT_W=16
  logic        cke_a, clr_a;
  logic [63:0] in_a;
  logic [3:0]  now_a, sticky_a;
  logic        any_a, fv_a;
  logic [63:0] cnt_a;
  logic [1:0]  fch_a;
  logic [15:0] fval_a;
  logic [31:0] ftime_a;
  // DUT B: PERSIST=1, CNT_W=2
  logic        cke_b, clr_b;
  logic [63:0] in_b;
  logic [3:0]  now_b, sticky_b;
  logic        any_b, fv_b;
  logic [7:0]  cnt_b;
  logic [1:0]  fch_b;
  logic [15:0] fval_b;
  logic [31:0] ftime_b;

  range_monitor_real #(.N_CH(4), .WIDTH(16), .EXPONENT(-12), .LO(-1.0), .HI(1.0),
                       .PERSIST(3), .CNT_W(16), .TIME_W(32)) u_a (
    .clk(clk), .rst_n(rst_n), .cke(cke_a), .clr(clr_a), .in(in_a),
    .viol_now(now_a), .viol_sticky(sticky_a), .viol_any(any_a), .viol_cnt(cnt_a),
    .first_valid(fv_a), .first_ch(fch_a), .first_val(fval_a), .first_time(ftime_a));

  range_monitor_real #(.N_CH(4), .WIDTH(16), .EXPONENT(-12), .LO(-1.0), .HI(1.0),
                       .PERSIST(1), .CNT_W(2), .TIME_W(32)) u_b (
    .clk(clk), .rst_n(rst_n), .cke(cke_b), .clr(clr_b), .in(in_b),
    .viol_now(now_b), .viol_sticky(sticky_b), .viol_any(any_b), .viol_cnt(cnt_b),
    .first_valid(fv_b), .first_ch(fch_b), .first_val(fval_b), .first_time(ftime_b));

  typedef struct packed {
    int         id;
    int         due;
    logic [3:0] mask;
  } ev_t;

  typedef struct packed {
    int          id;
    int          due;
    logic        sel;
    logic [3:0]  sticky;
    logic [63:0] cnt;
    logic        fv;
    logic [1:0]  fch;
    logic [15:0] fval;
    logic [31:0] ftime;
  } st_t;

  ev_t evq_a[$];
  ev_t evq_b[$];
  st_t stq[$];

  int cyc = 0;
  int vid = 0;
  int n_vec = 0;
  int n_bad = 0;
  logic done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] pack4(int c0, int c1, int c2, int c3);
    return {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  task automatic chk(string what, int id, logic [63:0] act, logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s (vec %0d): got %0h, required %0h", what, id, act, req);
    end else begin
      $display("ok   %s (vec %0d): %0h", what, id, act);
    end
  endtask

  ev_t ea, eb;
  st_t s;

  always @(negedge clk) begin
    if (now_a != 4'b0) begin
      if (evq_a.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL event_a: unexpected viol_now=%b at cycle %0d, required none", now_a, cyc);
      end else begin
        ea = evq_a.pop_front();
        chk("event_a mask", ea.id, 64'(now_a), 64'(ea.mask));
        chk("event_a cycle", ea.id, 64'(cyc), 64'(ea.due));
      end
    end
    if (now_b != 4'b0) begin
      if (evq_b.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL event_b: unexpected viol_now=%b at cycle %0d, required none", now_b, cyc);
      end else begin
        eb = evq_b.pop_front();
        chk("event_b mask", eb.id, 64'(now_b), 64'(eb.mask));
        chk("event_b cycle", eb.id, 64'(cyc), 64'(eb.due));
      end
    end
    while (stq.size() > 0 && stq[0].due <= cyc) begin
      s = stq.pop_front();
      if (s.sel == 1'b0) begin
        chk("a.sticky", s.id, 64'(sticky_a), 64'(s.sticky));
        chk("a.any", s.id, 64'(any_a), 64'(|s.sticky));
        chk("a.cnt", s.id, cnt_a, s.cnt);
        chk("a.first_valid", s.id, 64'(fv_a), 64'(s.fv));
        chk("a.first_ch", s.id, 64'(fch_a), 64'(s.fch));
        chk("a.first_val", s.id, 64'(fval_a), 64'(s.fval));
        chk("a.first_time", s.id, 64'(ftime_a), 64'(s.ftime));
      end else begin
        chk("b.sticky", s.id, 64'(sticky_b), 64'(s.sticky));
        chk("b.any", s.id, 64'(any_b), 64'(|s.sticky));
        chk("b.cnt", s.id, 64'(cnt_b), s.cnt);
        chk("b.first_valid", s.id, 64'(fv_b), 64'(s.fv));
        chk("b.first_ch", s.id, 64'(fch_b), 64'(s.fch));
        chk("b.first_val", s.id, 64'(fval_b), 64'(s.fval));
        chk("b.first_time", s.id, 64'(ftime_b), 64'(s.ftime));
      end
    end
    if (done || cyc > 3000) begin
      if (!done) begin
        n_vec++; n_bad++;
        $display("FAIL timeout: cycle %0d reached, required stimulus to finish", cyc);
      end
      while (evq_a.size() > 0) begin
        ea = evq_a.pop_front();
        n_vec++; n_bad++;
        $display("FAIL event_a missing (vec %0d): got none, required mask %b at cycle %0d", ea.id, ea.mask, ea.due);
      end
      while (evq_b.size() > 0) begin
        eb = evq_b.pop_front();
        n_vec++; n_bad++;
        $display("FAIL event_b missing (vec %0d): got none, required mask %b at cycle %0d", eb.id, eb.mask, eb.due);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Event expected from the sample about to be applied (visible after next edge).
  task automatic exp_ev(logic sel, logic [3:0] mask);
    ev_t e;
    vid++;
    e.id = vid; e.due = cyc + 1; e.mask = mask;
    if (sel) evq_b.push_back(e); else evq_a.push_back(e);
  endtask

  // Expected status at this cycle's checking edge.
  task automatic exp_st(logic sel, logic [3:0] sticky, logic [63:0] cnt, logic fv,
                        logic [1:0] fch, logic [15:0] fval, logic [31:0] ftime);
    st_t r;
    vid++;
    r.id = vid; r.due = cyc; r.sel = sel; r.sticky = sticky; r.cnt = cnt;
    r.fv = fv; r.fch = fch; r.fval = fval; r.ftime = ftime;
    stq.push_back(r);
  endtask

  initial begin
    // Reset held while out-of-range samples are offered: nothing may register.
    rst_n = 1'b0;
    cke_a = 1'b1; clr_a = 1'b0; in_a = pack4(9000, 9000, 9000, 9000);
    cke_b = 1'b1; clr_b = 1'b0; in_b = pack4(9000, 9000, 9000, 9000);
    tick(); tick();
    exp_st(1'b0, 4'b0, 64'h0, 1'b0, 2'd0, 16'h0, 32'd0);
    exp_st(1'b1, 4'b0, 64'h0, 1'b0, 2'd0, 16'h0, 32'd0);
    tick();
    rst_n = 1'b1;
    in_a = pack4(0, 0, 0, 0);
    cke_b = 1'b0; in_b = pack4(0, 0, 0, 0);

    // 1: 20 in-range samples on A (samples 0..19), limits included.
    for (int i = 0; i < 20; i++) begin
      in_a = pack4(i * 200 - 2000, HI_FIX, LO_FIX, -i * 100);
      tick();
    end
    exp_st(1'b0, 4'b0, 64'h0, 1'b0, 2'd0, 16'h0, 32'd0);

    // 2: ch1 out for 2 samples (20,21) then in-range (22): no event.
    in_a = pack4(0, HI_FIX + 1, 0, 0); tick(); tick();
    in_a = pack4(0, 100, 0, 0); tick();
    exp_st(1'b0, 4'b0, 64'h0, 1'b0, 2'd0, 16'h0, 32'd0);

    // 3: ch1 out for 5 samples (23..27); event completes on sample 25.
    in_a = pack4(0, HI_FIX + 1, 0, 0); tick(); tick();
    exp_ev(1'b0, 4'b0010); tick();
    in_a = pack4(0, 5000, 0, 0); tick(); tick();
    in_a = pack4(0, 0, 0, 0); tick();
    exp_st(1'b0, 4'b0010, 64'h0000_0000_0001_0000, 1'b1, 2'd1, 16'h1001, 32'd25);

    // 6a: exact limits are in range; lo_fix-1 on ch3 flags, capture unchanged.
    in_a = pack4(LO_FIX, 0, HI_FIX, LO_FIX); tick(); tick(); tick();
    in_a = pack4(0, 0, 0, LO_FIX - 1); tick(); tick();
    exp_ev(1'b0, 4'b1000); tick();
    in_a = pack4(0, 0, 0, 0); tick();
    exp_st(1'b0, 4'b1010, 64'h0001_0000_0001_0000, 1'b1, 2'd1, 16'h1001, 32'd25);

    // 4: B (PERSIST=1): 3 in-range samples (0..2), then ch0 and ch2 out on sample 3.
    cke_b = 1'b1; in_b = pack4(0, 0, 0, 0); tick(); tick(); tick();
    in_b = pack4(-5000, 0, HI_FIX + 1, 0);
    exp_ev(1'b1, 4'b0101); tick();
    in_b = pack4(0, 0, 0, 0); tick();
    exp_st(1'b1, 4'b0101, 64'h11, 1'b1, 2'd0, 16'hEC78, 32'd3);

    // 5: ch3 toggles out/in 5 times; CNT_W=2 count saturates at 3.
    for (int i = 0; i < 5; i++) begin
      in_b = pack4(0, 0, 0, (i % 2 == 0) ? HI_FIX + 1 : LO_FIX - 1);
      exp_ev(1'b1, 4'b1000); tick();
      in_b = pack4(0, 0, 0, 0); tick();
    end
    exp_st(1'b1, 4'b1101, 64'hD1, 1'b1, 2'd0, 16'hEC78, 32'd3);
    // 6th out sample coincides with clr: discarded, everything cleared.
    in_b = pack4(0, 0, 0, HI_FIX + 1); clr_b = 1'b1; tick();
    clr_b = 1'b0; in_b = pack4(0, 0, 0, 0);
    exp_st(1'b1, 4'b0, 64'h0, 1'b0, 2'd0, 16'h0, 32'd0);

    // 6b: two samples (0,1), then cke=0 for 4 cycles with ch1 out: nothing counts.
    tick(); tick();
    cke_b = 1'b0; in_b = pack4(0, HI_FIX + 1, 0, 0);
    tick(); tick(); tick(); tick();
    exp_st(1'b1, 4'b0, 64'h0, 1'b0, 2'd0, 16'h0, 32'd0);
    cke_b = 1'b1;
    exp_ev(1'b1, 4'b0010); tick();
    in_b = pack4(0, 0, 0, 0); tick();
    exp_st(1'b1, 4'b0010, 64'h04, 1'b1, 2'd1, 16'h1001, 32'd2);

    // 6c: A ch0 out for 2 samples, asynchronous reset mid-run, then 2 more out
    // samples after release: the partial run must not produce an event.
    in_a = pack4(5000, 0, 0, 0); tick(); tick();
    rst_n = 1'b0;
    exp_st(1'b0, 4'b0, 64'h0, 1'b0, 2'd0, 16'h0, 32'd0);
    exp_st(1'b1, 4'b0, 64'h0, 1'b0, 2'd0, 16'h0, 32'd0);
    tick();
    rst_n = 1'b1; tick(); tick();
    in_a = pack4(0, 0, 0, 0); tick();
    exp_st(1'b0, 4'b0, 64'h0, 1'b0, 2'd0, 16'h0, 32'd0);
    tick(); tick();
    done = 1'b1;
  end

endmodule
